// File: rtl/perceptron_nway.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_nway
// Brief    : N_IN-input signed fixed-point perceptron with a serial MAC, a
//            saturating accumulator and a full training pass over all weights.
//            Optional mistake counter: define PERCEPTRON_NWAY_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module perceptron_nway #(
    parameter int N_IN = 4,
    parameter int W    = 8,
    parameter int FRAC = 3,
    parameter int SW   = $clog2(N_IN + 3)
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          go,
    input  logic          update,
    input  logic          correct,
    input  logic [SW-1:0] sel_out,
    input  logic [W-1:0]  in_val,
    output logic          sync,
    output logic          done,
    output logic          classification,
    output logic [W-1:0]  out_val
);

    localparam int c_AW = W + $clog2(N_IN + 1);
    localparam int c_IW = $clog2(N_IN + 1);
    localparam int c_PW = 2 * W;
    localparam int c_XW = 2 * W + c_AW;

    localparam logic [c_IW-1:0]        c_LAST = c_IW'(N_IN);
    localparam logic [c_IW-1:0]        c_IONE = c_IW'(1);
    localparam logic signed [W-1:0]    c_ONE  = W'(1 << FRAC);
    localparam logic signed [c_XW-1:0] c_SMAX = c_XW'((2 ** (W - 1)) - 1);
    localparam logic signed [c_XW-1:0] c_SMIN = -c_SMAX - c_XW'(1);
    localparam logic [SW-1:0]          c_SEL_LAST_W = SW'(N_IN);
    localparam logic [SW-1:0]          c_SEL_ACC    = SW'(N_IN + 1);
    localparam logic [SW-1:0]          c_SEL_ERR    = SW'(N_IN + 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_LOAD_N  = 3'd2,
        S_LOAD_X  = 3'd3,
        S_MAC     = 3'd4,
        S_DECIDE  = 3'd5,
        S_UPD_MUL = 3'd6,
        S_UPD_ADD = 3'd7
    } t_state;

    t_state                   r_state;
    t_state                   w_next;
    logic signed [W-1:0]      r_w [0:N_IN];
    logic signed [W-1:0]      r_x [0:N_IN];
    logic signed [W-1:0]      r_n;
    logic signed [W-1:0]      r_p;
    logic signed [c_AW-1:0]   r_acc;
    logic [c_IW-1:0]          r_idx;
    logic                     r_upd;
    logic                     r_cor;
    logic                     r_class;

    logic                     w_class;
    logic                     w_to_upd;
    logic signed [W-1:0]      w_xsel;
    logic signed [c_PW-1:0]   w_mprod;
    logic signed [c_PW-1:0]   w_uprod;
    logic signed [c_XW-1:0]   w_ushift;
    logic signed [W-1:0]      w_mterm;
    logic signed [W-1:0]      w_uterm;
    logic signed [W-1:0]      w_wsum;
    logic [W-1:0]             w_acc_rb;
    logic [W-1:0]             w_err_rb;

    function automatic logic signed [W-1:0] f_sat(input logic signed [c_XW-1:0] v);
        if (v > c_SMAX)
            return c_SMAX[W-1:0];
        else if (v < c_SMIN)
            return c_SMIN[W-1:0];
        else
            return v[W-1:0];
    endfunction

    // Index 0 stands for the implicit bias input x0 = 1.0
    assign w_xsel   = (r_idx == '0) ? c_ONE : r_x[r_idx];
    assign w_mprod  = c_PW'(r_w[r_idx]) * c_PW'(w_xsel);
    assign w_uprod  = c_PW'(r_n) * c_PW'(w_xsel);
    assign w_mterm  = f_sat(c_XW'(w_mprod >>> FRAC));
    assign w_ushift = c_XW'(w_uprod >>> FRAC);
    assign w_uterm  = f_sat(r_cor ? w_ushift : -w_ushift);
    assign w_wsum   = f_sat(c_XW'(r_w[r_idx]) + c_XW'(r_p));
    assign w_class  = !r_acc[c_AW-1] && (r_acc != '0);
    assign w_acc_rb = f_sat(c_XW'(r_acc));

    // In DECIDE the fresh result is shown so it is valid together with done
    assign classification = (r_state == S_DECIDE) ? w_class : r_class;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        sync     = 1'b0;
        done     = 1'b0;
        w_to_upd = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go)
                    w_next = S_LOAD_W;
            end
            S_LOAD_W: begin
                sync = go;
                if (go && (r_idx == c_LAST))
                    w_next = S_LOAD_N;
            end
            S_LOAD_N: begin
                sync = go;
                if (go)
                    w_next = S_LOAD_X;
            end
            S_LOAD_X: begin
                sync = go;
                if (go && (r_idx == c_LAST))
                    w_next = S_MAC;
            end
            S_MAC: begin
                if (r_idx == c_LAST)
                    w_next = S_DECIDE;
            end
            S_DECIDE: begin
                w_to_upd = r_upd && (w_class != r_cor);
                if (w_to_upd) begin
                    w_next = S_UPD_MUL;
                end else begin
                    done   = 1'b1;
                    w_next = S_LOAD_X;
                end
            end
            S_UPD_MUL: begin
                w_next = S_UPD_ADD;
            end
            S_UPD_ADD: begin
                if (r_idx == c_LAST) begin
                    done   = 1'b1;
                    w_next = S_LOAD_X;
                end else begin
                    w_next = S_UPD_MUL;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i <= N_IN; i++) begin
                r_w[i] <= '0;
                r_x[i] <= '0;
            end
            r_n     <= '0;
            r_p     <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_upd   <= 1'b0;
            r_cor   <= 1'b0;
            r_class <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go)
                        r_idx <= '0;
                end
                S_LOAD_W: begin
                    if (go) begin
                        r_w[r_idx] <= in_val;
                        r_idx      <= (r_idx == c_LAST) ? '0 : r_idx + c_IONE;
                    end
                end
                S_LOAD_N: begin
                    if (go) begin
                        r_n   <= in_val;
                        r_idx <= c_IONE;
                    end
                end
                S_LOAD_X: begin
                    if (go) begin
                        r_x[r_idx] <= in_val;
                        if (r_idx == c_LAST) begin
                            r_upd <= update;
                            r_cor <= correct;
                            r_idx <= '0;
                        end else begin
                            r_idx <= r_idx + c_IONE;
                        end
                    end
                end
                S_MAC: begin
                    if (r_idx == '0)
                        r_acc <= c_AW'(r_w[0]);
                    else
                        r_acc <= r_acc + c_AW'(w_mterm);
                    if (r_idx != c_LAST)
                        r_idx <= r_idx + c_IONE;
                end
                S_DECIDE: begin
                    r_class <= w_class;
                    r_idx   <= w_to_upd ? '0 : c_IONE;
                end
                S_UPD_MUL: begin
                    r_p <= w_uterm;
                end
                S_UPD_ADD: begin
                    r_w[r_idx] <= w_wsum;
                    r_idx      <= (r_idx == c_LAST) ? c_IONE : r_idx + c_IONE;
                end
                default: ;
            endcase
        end
    end

`ifdef PERCEPTRON_NWAY_ERRCNT_EN
    logic [7:0] r_errcnt;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l)
            r_errcnt <= '0;
        else if ((r_state == S_DECIDE) && w_to_upd && (r_errcnt != 8'hFF))
            r_errcnt <= r_errcnt + 8'd1;
    end

    generate
        if (W >= 8) begin : g_err_zext
            assign w_err_rb = W'(r_errcnt);
        end else begin : g_err_sat
            assign w_err_rb = (r_errcnt > 8'((1 << W) - 1)) ? '1 : r_errcnt[W-1:0];
        end
    endgenerate
`else
    assign w_err_rb = '0;
`endif

    always_comb begin
        out_val = '0;
        if (sel_out <= c_SEL_LAST_W)
            out_val = r_w[sel_out[c_IW-1:0]];
        else if (sel_out == c_SEL_ACC)
            out_val = w_acc_rb;
        else if (sel_out == c_SEL_ERR)
            out_val = w_err_rb;
    end

endmodule
`default_nettype wire

// File: tb/tb_perceptron_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_perceptron_nway
// Brief    : Scoreboard-driven bench for perceptron_nway at default parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_perceptron_nway;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset_l = 1'b0;
    logic       go = 1'b0;
    logic       update = 1'b0;
    logic       correct = 1'b0;
    logic [2:0] sel_out = '0;
    logic [7:0] in_val = '0;
    logic       sync;
    logic       done;
    logic       classification;
    logic [7:0] out_val;

    typedef struct {
        logic cls;
        int   lat;
    } t_exp;

    t_exp sbq[$];
    int   total = 0;
    int   bad = 0;

    perceptron_nway dut (
        .clk            (clk),
        .reset_l        (reset_l),
        .go             (go),
        .update         (update),
        .correct        (correct),
        .sel_out        (sel_out),
        .in_val         (in_val),
        .sync           (sync),
        .done           (done),
        .classification (classification),
        .out_val        (out_val)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(posedge clk); #1;
        reset_l = 1'b0; go = 1'b0; update = 1'b0; correct = 1'b0; in_val = '0;
        repeat (2) @(posedge clk);
        #1 reset_l = 1'b1;
    endtask

    task automatic check_rb(input int sel, input logic [7:0] exp, input string nm);
        sel_out = 3'(sel);
        #1;
        total++;
        if (out_val !== exp) begin
            bad++;
            $display("FAIL %s: out_val=%h expected %h", nm, out_val, exp);
        end
    endtask

    task automatic load(input logic [7:0] w [5], input logic [7:0] n);
        @(posedge clk); #1;
        go = 1'b1; in_val = 8'h00;
        @(negedge clk);
        total++;
        if (sync !== 1'b0) begin bad++; $display("FAIL idle_sync: sync=%b expected 0", sync); end
        for (int i = 0; i <= N; i++) begin
            @(posedge clk); #1 in_val = w[i];
            @(negedge clk);
            total++;
            if (sync !== 1'b1) begin bad++; $display("FAIL load_w_sync[%0d]: sync=%b expected 1", i, sync); end
        end
        @(posedge clk); #1 in_val = n;
        @(negedge clk);
        total++;
        if (sync !== 1'b1) begin bad++; $display("FAIL load_n_sync: sync=%b expected 1", sync); end
        @(posedge clk); #1 go = 1'b0;
    endtask

    task automatic run_sample(input logic [7:0] x [4], input logic upd, input logic cor,
                              input logic exp_cls, input int exp_lat, input logic go_busy,
                              input string nm);
        t_exp e;
        int   k;
        bit   seen;
        e.cls = exp_cls;
        e.lat = exp_lat;
        sbq.push_back(e);
        for (int i = 0; i < N; i++) begin
            @(posedge clk); #1;
            go = 1'b1; in_val = x[i]; update = upd; correct = cor;
            @(negedge clk);
            total++;
            if (sync !== 1'b1) begin bad++; $display("FAIL %s x_sync[%0d]: sync=%b expected 1", nm, i, sync); end
        end
        // Flip the labels right after the latch; the result must not care
        @(posedge clk); #1;
        go = go_busy; in_val = 8'h5A; update = ~upd; correct = ~cor;
        seen = 1'b0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done && sync) begin bad++; $display("FAIL %s done_sync: both high at cycle %0d", nm, k); end
            if (go_busy) begin
                total++;
                if (sync !== 1'b0) begin bad++; $display("FAIL %s busy_sync: sync=%b expected 0", nm, sync); end
            end
            if (done) begin seen = 1'b1; break; end
        end
        e = sbq.pop_front();
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s timeout: no done within 40 cycles, expected %0d", nm, e.lat);
        end else begin
            total++;
            if (k !== e.lat) begin bad++; $display("FAIL %s latency: got %0d expected %0d", nm, k, e.lat); end
            total++;
            if (classification !== e.cls) begin bad++; $display("FAIL %s class: got %b expected %b", nm, classification, e.cls); end
        end
        @(posedge clk); #1;
        go = 1'b0; update = 1'b0; correct = 1'b0;
        @(negedge clk);
        total++;
        if (classification !== e.cls) begin bad++; $display("FAIL %s class_held: got %b expected %b", nm, classification, e.cls); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL %s done_pulse: done=%b expected 0", nm, done); end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if (done !== 1'b0 || sync !== 1'b0 || classification !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs: done=%b sync=%b class=%b expected 000", done, sync, classification);
        end
        for (int s = 0; s < 8; s++) check_rb(s, 8'h00, "reset_rb");
    endtask

    task automatic test_forward();
        logic [7:0] w [5];
        logic [7:0] x [4];
        do_reset();
        w = '{8'd8, 8'd8, 8'd8, 8'd8, 8'd8};
        x = '{8'd8, 8'd8, 8'd8, 8'd8};
        load(w, 8'd8);
        run_sample(x, 1'b0, 1'b0, 1'b1, 6, 1'b0, "forward");
        check_rb(5, 8'd40, "forward_acc");
        for (int s = 0; s <= N; s++) check_rb(s, 8'd8, "forward_w");
        check_rb(7, 8'h00, "sel_unused");
    endtask

    task automatic test_update_pos();
        logic [7:0] w [5];
        logic [7:0] x [4];
        do_reset();
        w = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        x = '{8'd8, 8'd0, 8'd0, 8'd0};
        load(w, 8'd8);
        run_sample(x, 1'b1, 1'b1, 1'b0, 16, 1'b0, "upd_pos");
        check_rb(0, 8'd8, "upd_pos_w0");
        check_rb(1, 8'd8, "upd_pos_w1");
        for (int s = 2; s <= N; s++) check_rb(s, 8'd0, "upd_pos_wk");
    endtask

    task automatic test_update_neg();
        logic [7:0] w [5];
        logic [7:0] x [4];
        do_reset();
        w = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
        x = '{8'd8, 8'd0, 8'd0, 8'd0};
        load(w, 8'd8);
        run_sample(x, 1'b1, 1'b0, 1'b1, 16, 1'b0, "upd_neg");
        check_rb(0, 8'h00, "upd_neg_w0");
        check_rb(1, 8'hF8, "upd_neg_w1");
        check_rb(2, 8'h00, "upd_neg_w2");
    endtask

    task automatic test_saturation();
        logic [7:0] w [5];
        logic [7:0] x [4];
        x = '{8'd127, 8'd0, 8'd0, 8'd0};
        do_reset();
        w = '{8'd0, 8'd127, 8'd0, 8'd0, 8'd0};
        load(w, 8'd8);
        run_sample(x, 1'b0, 1'b0, 1'b1, 6, 1'b0, "sat_pos");
        check_rb(5, 8'd127, "sat_pos_acc");
        do_reset();
        w = '{8'd0, 8'h80, 8'd0, 8'd0, 8'd0};
        load(w, 8'd8);
        run_sample(x, 1'b0, 1'b0, 1'b0, 6, 1'b0, "sat_neg");
        check_rb(5, 8'h80, "sat_neg_acc");
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [5];
        logic [7:0] x [4];
        logic [7:0] exp_err;
        do_reset();
        w = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        x = '{8'd8, 8'd0, 8'd0, 8'd0};
        load(w, 8'd8);
        run_sample(x, 1'b1, 1'b1, 1'b0, 16, 1'b0, "b2b_miss1");
        // Now w0 = w1 = 1.0: acc = 2.0 agrees with the label, so no training
        run_sample(x, 1'b1, 1'b1, 1'b1, 6, 1'b1, "b2b_agree");
        check_rb(0, 8'd8, "b2b_agree_w0");
        check_rb(1, 8'd8, "b2b_agree_w1");
        check_rb(5, 8'd16, "b2b_agree_acc");
        run_sample(x, 1'b1, 1'b0, 1'b1, 16, 1'b0, "b2b_miss2");
        check_rb(0, 8'd0, "b2b_miss2_w0");
        check_rb(1, 8'd0, "b2b_miss2_w1");
`ifdef PERCEPTRON_NWAY_ERRCNT_EN
        exp_err = 8'd2;
`else
        exp_err = 8'd0;
`endif
        check_rb(6, exp_err, "errcnt");
    endtask

    task automatic test_reset_mid_update();
        logic [7:0] w [5];
        logic [7:0] x [4];
        bit         seen_done;
        do_reset();
        w = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        x = '{8'd8, 8'd0, 8'd0, 8'd0};
        load(w, 8'd8);
        for (int i = 0; i < N; i++) begin
            @(posedge clk); #1;
            go = 1'b1; in_val = x[i]; update = 1'b1; correct = 1'b1;
        end
        @(posedge clk); #1 go = 1'b0;
        seen_done = 1'b0;
        // Cycle 10 after the last sync is the UPD_ADD for w1; w0 is already trained
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        total++;
        if (seen_done) begin bad++; $display("FAIL mid_upd_early_done: done seen before cycle 10, expected none"); end
        check_rb(0, 8'd8, "mid_upd_live_w0");
        reset_l = 1'b0;
        #1;
        check_rb(0, 8'd0, "mid_rst_w0");
        check_rb(1, 8'd0, "mid_rst_w1");
        check_rb(5, 8'd0, "mid_rst_acc");
        total++;
        if (done !== 1'b0 || classification !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_outs: done=%b class=%b expected 00", done, classification);
        end
        @(posedge clk); #1 reset_l = 1'b1;
        w = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        load(w, 8'd8);
        check_rb(0, 8'd5, "reload_w0");
        check_rb(4, 8'd9, "reload_w4");
        run_sample(x, 1'b0, 1'b0, 1'b1, 6, 1'b0, "reload_run");
        check_rb(5, 8'd11, "reload_acc");
    endtask

    initial begin
        test_reset();
        test_forward();
        test_update_pos();
        test_update_neg();
        test_saturation();
        test_back_to_back();
        test_reset_mid_update();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perceptron_nway.md
Name: perceptron_nway

Overview:
- Parametrised successor to the 2-input fixed-point perceptron.
- Generalised to N_IN inputs, W-bit signed fixed point with FRAC fraction bits, and a guarded saturating accumulator.
- Multiply-accumulate runs serially, one term per cycle. A training pass updates every weight, not just three.
- Sits between the user-facing serial load interface (go/sync) and the readback mux.

Parameters:
- N_IN, 4, number of feature inputs x1..xN_IN (weights w0..wN_IN, w0 = bias)
- W, 8, datapath width; signed two's complement fixed point
- FRAC, 3, fraction bits (1.0 = 1<<FRAC)

Ports:
- clk  in  1  clock, rising edge
- reset_l  in  1  asynchronous, active-low reset
- go  in  1  level; accepts in_val on each cycle it is high in a load state
- update  in  1  train enable; latched with last x
- correct  in  1  label (1 = positive class); latched with last x
- sel_out  in  SW=$clog2(N_IN+3)  readback select
- in_val  in  W  serial load data
- sync  out  1  one-cycle pulse: in_val accepted this cycle
- done  out  1  one-cycle pulse: sample finished
- classification  out  1  registered result, valid from done, held until next done
- out_val  out  W  readback: sel 0..N_IN = w0..wN_IN; N_IN+1 = accumulator saturated to W; N_IN+2 = error count (optional); others 0

Behaviour:
- Reset (async, reset_l low): state IDLE; all weights, n, x, acc, product reg, index counter, classification, sync, done = 0; out_val = 0.
- States and transitions:
  - IDLE: go → LOAD_W, idx=0.
  - LOAD_W: each go cycle stores w[idx], idx++. After w[N_IN] → LOAD_N.
  - LOAD_N: go stores n → LOAD_X, idx=1.
  - LOAD_X: each go stores x[idx]. On x[N_IN], also latch update/correct → MAC, idx=0.
  - MAC, N_IN+1 cycles: acc = w0, then acc += sat(w[i]*x[i]) for i=1..N_IN.
  - DECIDE, 1 cycle: classification <= (acc > 0), strict signed compare.
    - If !update or classification==correct: done → LOAD_X.
    - Else → UPD_MUL, idx=0.
  - UPD_MUL: p = sat(n*x[idx]*d), where x0 = 1.0 and d = +1.0 if correct else -1.0.
  - UPD_ADD: w[idx] = sat(w[idx]+p), idx++. After idx = N_IN: done → LOAD_X.
- Each weight update costs 2 cycles. Weights and n persist across samples; reload requires reset.
- Arithmetic:
  - Products are full 2W signed, arithmetic shift right by FRAC, saturated to W (max 2^(W-1)-1, min -2^(W-1)).
  - The accumulator is W+$clog2(N_IN+1) bits and never wraps.
  - Readback and compare use the full accumulator; readback is saturated.
- Latency:
  - No update: done in the (N_IN+2)th cycle after the cycle of the last sync.
  - With update: add 2*(N_IN+1) cycles.
- Handshake:
  - sync is asserted combinationally in the same cycle the value is accepted (go high in a load state).
  - go is ignored in MAC/DECIDE/UPD states; no sync there.
  - done and sync are never high together.
- Boundaries:
  - update and correct changing after latch have no effect.
  - Reset mid-MAC/UPD aborts immediately: partial weight updates are lost and everything is cleared.
  - sel_out is sampled combinationally at any time, including mid-update, and shows live register values.

Optional Feature:
- Macro: PERCEPTRON_NWAY_ERRCNT_EN.
- Defined: 8-bit saturating counter (stops at 255), incremented on each DECIDE that enters UPD_MUL; cleared only by reset. Readable at sel_out = N_IN+2, zero-extended or saturated to W.
- Undefined: no counter logic; sel N_IN+2 returns 0.

Test Plan:
- Defaults (N_IN=4, W=8, FRAC=3); load w=[8,8,8,8,8], n=8, x=[8,8,8,8], update=0 → acc readback 40, classification=1, done 6 cycles after last sync, weights unchanged.
- w all 0, n=8, x=[8,0,0,0], update=1, correct=1 → class 0, update; w0=8, w1=8, w2..w4=0; done 16 cycles after last sync.
- Same with correct=0 and w0=8 preloaded → class 1 ≠ 0; w0=0, w1=-8 (0xF8).
- w1=127, x1=127, rest 0 → product saturates to 127; acc=127, class 1. w1=-128, x1=127 → acc readback -128 (0x80).
- update=1 with class==correct → no weight change; done in DECIDE. Reset pulsed in UPD_ADD → all regs 0, state IDLE, next go loads w0.
- With PERCEPTRON_NWAY_ERRCNT_EN: two mistaken training samples, one correct → sel 6 reads 2. Without macro: sel 6 reads 0.
